// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_pipe data RAM: size codes,
// byte-lane mask derivation and the response record carried down the read pipe.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    // Widest supported word; narrower builds leave the upper rdata bits at zero.
    localparam int MAX_DATA_W = 64;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  err;
        logic [MAX_DATA_W-1:0] rdata;
    } resp_t;

    // Low address bits are ignored below the access size, which is what
    // forces a misaligned access onto its aligned lane group.
    function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                             input logic [2:0] addr_lo,
                                             input int         nb);
        logic [7:0] m;
        logic [7:0] lanes;
        lanes = 8'((16'd1 << nb) - 16'd1);
        case (size)
            SZ_BYTE: m = 8'h01 << addr_lo;
            SZ_HALF: m = 8'h03 << {addr_lo[2:1], 1'b0};
            SZ_WORD: m = 8'h0F << {addr_lo[2], 2'b00};
            default: m = 8'hFF;
        endcase
        return m & lanes;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [2:0] addr_lo);
        logic mis;
        case (size)
            SZ_HALF:  mis = addr_lo[0];
            SZ_WORD:  mis = |addr_lo[1:0];
            SZ_DWORD: mis = |addr_lo;
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// LSU-side bus of the data RAM: req/gnt request channel and rvalid response channel.
interface dmem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    localparam int NB = DATA_W / 8;

    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [1:0]        size_i;
    logic [NB-1:0]     be_i;
    logic [DATA_W-1:0] wdata_i;
    logic              gnt_o;
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;

    modport master (
        output req_i, we_i, addr_i, size_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, size_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/dmem_resp_pipe.sv
// Fixed-latency response delay line for dmem_pipe; cleared by reset so
// in-flight responses are dropped rather than delivered late.
module dmem_resp_pipe
    import dmem_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic  clk_i,
    input  logic  reset_ni,
    input  resp_t resp_i,
    output resp_t resp_o
);

    resp_t stg [LAT];
    resp_t src [LAT];

    assign src[0] = resp_i;
    for (genvar i = 1; i < LAT; i++) begin : g_src
        assign src[i] = stg[i-1];
    end

    // Bubbles only clear the valid bit, so the final stage keeps presenting
    // the last delivered payload while rvalid is low.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < LAT; i++) stg[i] <= '0;
        end else begin
            for (int i = 0; i < LAT; i++) begin
                if (src[i].valid) stg[i] <= src[i];
                else              stg[i].valid <= 1'b0;
            end
        end
    end

    assign resp_o = stg[LAT-1];

endmodule

// File: rtl/dmem_pipe.sv
// Word-organised data RAM for the LSU with size-aware lane masking and READ_LAT response latency.
// Define DMEM_ERR_EN to flag misaligned/out-of-range accesses via err_o instead of aligning/dropping.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 2048,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h0001_0400),
    parameter int                READ_LAT    = 1
) (
    input logic   clk_i,
    input logic   reset_ni,
    dmem_if.slave bus
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int XW = ADDR_W - LB;

    logic              ready_q;
    logic [ADDR_W-1:0] off;
    logic [XW-1:0]     idx_full;
    logic [IW-1:0]     idx;
    logic              in_range;
    logic              err;
    logic              wr_en;
    logic [NB-1:0]     emask;
    logic [DATA_W-1:0] mem_word;
    logic [DATA_W-1:0] rd_masked;
    resp_t             resp_in;
    resp_t             resp_out;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) ready_q <= 1'b0;
        else           ready_q <= 1'b1;
    end

    assign bus.gnt_o = bus.req_i & ready_q;

    // Subtract first so addresses below the base wrap to a huge index and fail the range check.
    assign off      = bus.addr_i - BASE_ADDR;
    assign idx_full = off[ADDR_W-1:LB];
    assign idx      = idx_full[IW-1:0];
    assign in_range = idx_full < XW'(DEPTH_WORDS);
    assign emask    = NB'(lane_mask(bus.size_i, 3'(bus.addr_i[LB-1:0]), NB)) & bus.be_i;

    logic unused_off_lo;
    assign unused_off_lo = ^off[LB-1:0];

`ifdef DMEM_ERR_EN
    assign err = ~in_range | is_misaligned(bus.size_i, 3'(bus.addr_i[LB-1:0]));
`else
    assign err = 1'b0;
`endif

    assign wr_en = bus.gnt_o & bus.we_i & in_range & ~err;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (emask[b]) mem[idx][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
            end
        end
    end

    assign mem_word = mem[idx];

    always_comb begin
        rd_masked = '0;
        for (int b = 0; b < NB; b++) begin
            if (emask[b]) rd_masked[b*8 +: 8] = mem_word[b*8 +: 8];
        end
    end

    always_comb begin
        resp_in       = '0;
        resp_in.valid = bus.gnt_o;
        resp_in.we    = bus.we_i;
        resp_in.err   = err;
        resp_in.rdata = MAX_DATA_W'(in_range ? rd_masked : '0);
    end

    dmem_resp_pipe #(.LAT(READ_LAT)) u_resp_pipe (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .resp_i   (resp_in),
        .resp_o   (resp_out)
    );

    assign bus.rvalid_o = resp_out.valid;
    assign bus.err_o    = resp_out.valid & resp_out.err;
    assign bus.rdata_o  = (resp_out.we | resp_out.err) ? '0 : resp_out.rdata[DATA_W-1:0];

    if (DATA_W < MAX_DATA_W) begin : g_narrow
        logic unused_rdata_hi;
        assign unused_rdata_hi = ^resp_out.rdata[MAX_DATA_W-1:DATA_W];
    end

endmodule
